// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation error monitor: data width,
// controller states and the absolute-difference helper.
package interp_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    // One extra bit keeps the unsigned difference signed without wrap; the
    // magnitude of two DATA_W-bit values always fits back into DATA_W bits.
    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] d;
        logic signed [DATA_W:0] n;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        n = -d;
        return d[DATA_W] ? n[DATA_W-1:0] : d[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/interp_error_monitor_err_tracker.sv
// Per-method error statistics: running error sum plus the largest error and
// the x where that maximum was first seen.
module err_tracker
    import interp_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SUM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] err_i,
    input  logic [WIDTH-1:0] x_i,
    output logic [SUM_W-1:0] sum_o,
    output logic [WIDTH-1:0] max_o,
    output logic [WIDTH-1:0] max_x_o
);

    logic [SUM_W-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] max_x_q, max_x_d;

    always_comb begin
        sum_d   = sum_q;
        max_d   = max_q;
        max_x_d = max_x_q;
        if (clr_i) begin
            sum_d   = '0;
            max_d   = '0;
            max_x_d = '0;
        end else if (vld_i) begin
            sum_d = sum_q + SUM_W'(err_i);
            // Strictly greater keeps the earliest x on ties.
            if (err_i > max_q) begin
                max_d   = err_i;
                max_x_d = x_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            max_q   <= '0;
            max_x_q <= '0;
        end else begin
            sum_q   <= sum_d;
            max_q   <= max_d;
            max_x_q <= max_x_d;
        end
    end

    assign sum_o   = sum_q;
    assign max_o   = max_q;
    assign max_x_o = max_x_q;

endmodule

// File: rtl/interp_error_monitor.sv
// Measures linear and quadratic interpolation error against the exact value
// over a window of samples and reports sums and maxima via valid/ack.
module interp_error_monitor
    import interp_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int WINDOW = 256,
    parameter int SUM_W  = WIDTH + $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] x_input,
    input  logic [WIDTH-1:0] y_output_linear,
    input  logic [WIDTH-1:0] y_output_quadratic,
    input  logic [WIDTH-1:0] y_output_exact,
    input  logic             result_ack,
    output logic             busy,
    output logic             result_valid,
    output logic [SUM_W-1:0] sum_err_linear,
    output logic [SUM_W-1:0] sum_err_quadratic,
    output logic [WIDTH-1:0] max_err_linear,
    output logic [WIDTH-1:0] max_err_quadratic,
    output logic [WIDTH-1:0] max_x_linear,
    output logic [WIDTH-1:0] max_x_quadratic,
    output logic             quadratic_better
);

    localparam int CNT_W = $clog2(WINDOW) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drain_q, drain_d;
    logic             accept, clr, rpt_load;

    // The counter saturates at WINDOW so the cycle after the last accepted
    // sample ignores sample_valid while the FSM moves on to DRAIN.
    assign accept   = (state_q == ACCUM) && sample_valid && (cnt_q != CNT_W'(WINDOW));
    assign clr      = (state_q == IDLE) && start;
    assign rpt_load = (state_q == DRAIN) && drain_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_q == CNT_W'(WINDOW)) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = REPORT;
                end else begin
                    drain_d = 1'b1;
                end
            end
            REPORT: begin
                if (result_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    logic             vld_p1_q;
    logic [WIDTH-1:0] x_p1_q, lin_p1_q, quad_p1_q, ex_p1_q;
    logic             vld_p2_q;
    logic [WIDTH-1:0] x_p2_q, err_lin_p2_q, err_quad_p2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q      <= 1'b0;
            x_p1_q        <= '0;
            lin_p1_q      <= '0;
            quad_p1_q     <= '0;
            ex_p1_q       <= '0;
            vld_p2_q      <= 1'b0;
            x_p2_q        <= '0;
            err_lin_p2_q  <= '0;
            err_quad_p2_q <= '0;
        end else begin
            // Stage 1: capture accepted sample
            vld_p1_q <= accept;
            if (accept) begin
                x_p1_q    <= x_input;
                lin_p1_q  <= y_output_linear;
                quad_p1_q <= y_output_quadratic;
                ex_p1_q   <= y_output_exact;
            end
            // Stage 2: absolute errors
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                x_p2_q        <= x_p1_q;
                err_lin_p2_q  <= abs_diff(lin_p1_q, ex_p1_q);
                err_quad_p2_q <= abs_diff(quad_p1_q, ex_p1_q);
            end
        end
    end

    // Stage 3: accumulate sums and maxima
    logic [SUM_W-1:0] acc_sum_lin, acc_sum_quad;
    logic [WIDTH-1:0] acc_max_lin, acc_max_quad, acc_mx_lin, acc_mx_quad;

    err_tracker #(.WIDTH(WIDTH), .SUM_W(SUM_W)) u_trk_lin (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .vld_i   (vld_p2_q),
        .err_i   (err_lin_p2_q),
        .x_i     (x_p2_q),
        .sum_o   (acc_sum_lin),
        .max_o   (acc_max_lin),
        .max_x_o (acc_mx_lin)
    );

    err_tracker #(.WIDTH(WIDTH), .SUM_W(SUM_W)) u_trk_quad (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .vld_i   (vld_p2_q),
        .err_i   (err_quad_p2_q),
        .x_i     (x_p2_q),
        .sum_o   (acc_sum_quad),
        .max_o   (acc_max_quad),
        .max_x_o (acc_mx_quad)
    );

    logic [SUM_W-1:0] sum_lin_q, sum_quad_q;
    logic [WIDTH-1:0] max_lin_q, max_quad_q, mx_lin_q, mx_quad_q;
    logic             qbetter_q;

    // Results are frozen on entry to REPORT and kept until the next report.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_lin_q  <= '0;
            sum_quad_q <= '0;
            max_lin_q  <= '0;
            max_quad_q <= '0;
            mx_lin_q   <= '0;
            mx_quad_q  <= '0;
            qbetter_q  <= 1'b0;
        end else if (rpt_load) begin
            sum_lin_q  <= acc_sum_lin;
            sum_quad_q <= acc_sum_quad;
            max_lin_q  <= acc_max_lin;
            max_quad_q <= acc_max_quad;
            mx_lin_q   <= acc_mx_lin;
            mx_quad_q  <= acc_mx_quad;
            qbetter_q  <= (acc_sum_quad < acc_sum_lin);
        end
    end

    assign busy              = (state_q == ACCUM) || (state_q == DRAIN);
    assign result_valid      = (state_q == REPORT);
    assign sum_err_linear    = sum_lin_q;
    assign sum_err_quadratic = sum_quad_q;
    assign max_err_linear    = max_lin_q;
    assign max_err_quadratic = max_quad_q;
    assign max_x_linear      = mx_lin_q;
    assign max_x_quadratic   = mx_quad_q;
    assign quadratic_better  = qbetter_q;

endmodule

// File: tb/tb_interp_error_monitor.sv
// Directed bench for interp_error_monitor: full-window sweeps with known
// error patterns, gapped input, mid-window reset and REPORT hold behaviour.
module tb_interp_error_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [7:0]  x_input = '0;
    logic [7:0]  y_output_linear = '0;
    logic [7:0]  y_output_quadratic = '0;
    logic [7:0]  y_output_exact = '0;
    logic        result_ack = 1'b0;
    logic        busy, result_valid, quadratic_better;
    logic [15:0] sum_err_linear, sum_err_quadratic;
    logic [7:0]  max_err_linear, max_err_quadratic, max_x_linear, max_x_quadratic;

    int tests = 0;
    int fails = 0;

    interp_error_monitor dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .sample_valid       (sample_valid),
        .x_input            (x_input),
        .y_output_linear    (y_output_linear),
        .y_output_quadratic (y_output_quadratic),
        .y_output_exact     (y_output_exact),
        .result_ack         (result_ack),
        .busy               (busy),
        .result_valid       (result_valid),
        .sum_err_linear     (sum_err_linear),
        .sum_err_quadratic  (sum_err_quadratic),
        .max_err_linear     (max_err_linear),
        .max_err_quadratic  (max_err_quadratic),
        .max_x_linear       (max_x_linear),
        .max_x_quadratic    (max_x_quadratic),
        .quadratic_better   (quadratic_better)
    );

    always #5 clk = ~clk;

    // mode 0: all equal; mode 1: exact=x/2, lin=exact+2, quad=exact except
    // quad=exact-5 at x=100; mode 2: exact=0, lin=255, quad=0.
    task automatic set_sample(input int mode, input int x);
        logic [7:0] ex;
        x_input = 8'(x);
        case (mode)
            0: begin ex = 8'(x); y_output_linear = ex; y_output_quadratic = ex; end
            1: begin
                ex = 8'(x >> 1);
                y_output_linear    = ex + 8'd2;
                y_output_quadratic = (x == 100) ? ex - 8'd5 : ex;
            end
            default: begin ex = 8'd0; y_output_linear = 8'd255; y_output_quadratic = 8'd0; end
        endcase
        y_output_exact = ex;
    endtask

    // Starts a window, feeds nsamp samples and, for a full window, returns the
    // number of edges from the last acceptance to result_valid (-1 if none).
    task automatic drive_window(input int mode, input bit gap, input int nsamp, output int lat);
        int i;
        int cyc;
        int n;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        i = 0;
        cyc = 0;
        while (i < nsamp) begin
            if (gap && cyc[0]) begin
                sample_valid = 1'b0;
                x_input = 8'hAA; y_output_linear = 8'hFF;
                y_output_quadratic = 8'h00; y_output_exact = 8'h80;
            end else begin
                sample_valid = 1'b1;
                set_sample(mode, i);
                i++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        lat = -1;
        if (nsamp == 256) begin
            n = 0;
            while (!result_valid && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            if (result_valid) lat = n;
        end
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", result_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests++; if (sum_err_linear !== 16'd0 || sum_err_quadratic !== 16'd0) begin fails++; $display("FAIL reset_sums got %0d/%0d want 0/0", sum_err_linear, sum_err_quadratic); end
        tests++; if ({max_err_linear, max_err_quadratic, max_x_linear, max_x_quadratic, quadratic_better} !== 33'd0) begin fails++; $display("FAIL reset_max got %0d %0d %0d %0d %0b want 0", max_err_linear, max_err_quadratic, max_x_linear, max_x_quadratic, quadratic_better); end
    endtask

    task automatic test_zero_error();
        int lat;
        drive_window(0, 1'b0, 256, lat);
        tests++; if (lat !== 3) begin fails++; $display("FAIL zero_latency got %0d want 3", lat); end
        tests++; if (sum_err_linear !== 16'd0 || sum_err_quadratic !== 16'd0) begin fails++; $display("FAIL zero_sums got %0d/%0d want 0/0", sum_err_linear, sum_err_quadratic); end
        tests++; if (max_err_linear !== 8'd0 || max_err_quadratic !== 8'd0) begin fails++; $display("FAIL zero_max got %0d/%0d want 0/0", max_err_linear, max_err_quadratic); end
        tests++; if (max_x_linear !== 8'd0 || max_x_quadratic !== 8'd0) begin fails++; $display("FAIL zero_maxx got %0d/%0d want 0/0", max_x_linear, max_x_quadratic); end
        tests++; if (quadratic_better !== 1'b0) begin fails++; $display("FAIL zero_qbetter got %0b want 0", quadratic_better); end
        do_ack();
        tests++; if (result_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL zero_ack got valid=%0b busy=%0b want 0/0", result_valid, busy); end
    endtask

    task automatic test_offset_errors(input bit gap, input string tag);
        int lat;
        drive_window(1, gap, 256, lat);
        tests++; if (lat !== 3) begin fails++; $display("FAIL %s_latency got %0d want 3", tag, lat); end
        tests++; if (sum_err_linear !== 16'd512) begin fails++; $display("FAIL %s_sum_lin got %0d want 512", tag, sum_err_linear); end
        tests++; if (max_err_linear !== 8'd2 || max_x_linear !== 8'd0) begin fails++; $display("FAIL %s_max_lin got %0d@%0d want 2@0", tag, max_err_linear, max_x_linear); end
        tests++; if (sum_err_quadratic !== 16'd5) begin fails++; $display("FAIL %s_sum_quad got %0d want 5", tag, sum_err_quadratic); end
        tests++; if (max_err_quadratic !== 8'd5 || max_x_quadratic !== 8'd100) begin fails++; $display("FAIL %s_max_quad got %0d@%0d want 5@100", tag, max_err_quadratic, max_x_quadratic); end
        tests++; if (quadratic_better !== 1'b1) begin fails++; $display("FAIL %s_qbetter got %0b want 1", tag, quadratic_better); end
        do_ack();
    endtask

    task automatic test_worst_case();
        int lat;
        drive_window(2, 1'b0, 256, lat);
        tests++; if (lat !== 3) begin fails++; $display("FAIL worst_latency got %0d want 3", lat); end
        tests++; if (sum_err_linear !== 16'd65280) begin fails++; $display("FAIL worst_sum_lin got %0d want 65280", sum_err_linear); end
        tests++; if (max_err_linear !== 8'd255 || max_x_linear !== 8'd0) begin fails++; $display("FAIL worst_max_lin got %0d@%0d want 255@0", max_err_linear, max_x_linear); end
        tests++; if (sum_err_quadratic !== 16'd0 || quadratic_better !== 1'b1) begin fails++; $display("FAIL worst_quad got %0d qb=%0b want 0 qb=1", sum_err_quadratic, quadratic_better); end
        do_ack();
    endtask

    task automatic test_reset_mid_window();
        int lat;
        drive_window(2, 1'b0, 100, lat);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy got %0b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (busy !== 1'b0 || result_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_state got busy=%0b valid=%0b want 0/0", busy, result_valid); end
        tests++; if (sum_err_linear !== 16'd0 || max_err_linear !== 8'd0) begin fails++; $display("FAIL mid_rst_outputs got %0d/%0d want 0/0", sum_err_linear, max_err_linear); end
        test_offset_errors(1'b0, "after_rst");
    endtask

    task automatic test_report_hold();
        int lat;
        int unstable;
        drive_window(2, 1'b0, 256, lat);
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            @(posedge clk); #1;
            if (result_valid !== 1'b1 || sum_err_linear !== 16'd65280 || max_err_linear !== 8'd255 || busy !== 1'b0) unstable++;
        end
        start = 1'b0;
        tests++; if (unstable !== 0) begin fails++; $display("FAIL hold_stable got %0d unstable cycles want 0", unstable); end
        start = 1'b1;
        result_ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        result_ack = 1'b0;
        tests++; if (result_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL hold_ack_start got valid=%0b busy=%0b want 0/0", result_valid, busy); end
        tests++; if (sum_err_linear !== 16'd65280) begin fails++; $display("FAIL hold_keep got %0d want 65280", sum_err_linear); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_idle got busy=%0b want 0", busy); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_restart got busy=%0b want 1", busy); end
    endtask

    initial begin
        test_reset();
        test_zero_error();
        test_offset_errors(1'b0, "offset");
        test_worst_case();
        test_offset_errors(1'b1, "gapped");
        test_reset_mid_window();
        test_report_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/interp_error_monitor.md
Name: interp_error_monitor

Overview:
- Sits directly downstream of Main and consumes its x_input, y_output_linear, y_output_quadratic and y_output_exact over a window of samples.
- For each method it computes the absolute error against the exact value, accumulates the error sum, and tracks the maximum error and the x at which it occurred.
- Results are presented through a valid/ack handshake, so a bench or host can compare linear and quadratic interpolation over a full sweep.

Parameters:
- WIDTH, 8, data width of x and y.
- WINDOW, 256, number of samples per measurement; must be a power of two and at least 2.
- SUM_W, WIDTH+$clog2(WINDOW), width of the error-sum accumulators (16 at defaults).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a window; honoured only in IDLE.
- sample_valid  in  1  the four data inputs are valid this cycle.
- x_input  in  WIDTH  x presented to Main.
- y_output_linear  in  WIDTH  linear result from Main.
- y_output_quadratic  in  WIDTH  quadratic result from Main.
- y_output_exact  in  WIDTH  exact result from Main.
- result_ack  in  1  consumer accepts the results.
- busy  out  1  high in ACCUM and DRAIN.
- result_valid  out  1  results are stable and valid.
- sum_err_linear  out  SUM_W  sum of |lin-exact|.
- sum_err_quadratic  out  SUM_W  sum of |quad-exact|.
- max_err_linear  out  WIDTH  maximum |lin-exact|.
- max_err_quadratic  out  WIDTH  maximum |quad-exact|.
- max_x_linear  out  WIDTH  x at the first occurrence of max_err_linear.
- max_x_quadratic  out  WIDTH  x at the first occurrence of max_err_quadratic.
- quadratic_better  out  1  sum_err_quadratic < sum_err_linear; 0 on a tie.

Behaviour:
- Reset: every output, register and counter is 0; state is IDLE. Reset asserted in any state, including mid-window, discards all partial results on that edge.
- States:
  - IDLE: start=1 clears the accumulators, maxima and counter, then goes to ACCUM.
  - ACCUM: each cycle with sample_valid=1 is one accepted sample. The accepted sample at count WINDOW-1 moves to DRAIN.
  - DRAIN: lasts exactly 2 cycles, then goes to REPORT.
  - REPORT: result_valid=1. result_ack=1 goes to IDLE, and result_valid falls on the same edge.
- Ignored inputs:
  - sample_valid outside ACCUM.
  - start outside IDLE.
  - result_ack outside REPORT.
- Pipeline:
  - Stage 1 registers the inputs on acceptance.
  - Stage 2 computes the absolute differences with WIDTH+1-bit subtraction; the magnitude fits in WIDTH bits (0..255).
  - Stage 3 updates the sums and maxima.
- Latency: if the last sample is accepted at edge k, result_valid is high after edge k+3.
- Max tracking: update only when the new error is strictly greater than the stored maximum, so ties keep the earliest x. The initial maximum is 0 with max_x=0; a window of all-zero errors therefore reports max_x=0.
- Sums cannot overflow: WINDOW*(2^WIDTH-1) < 2^SUM_W. No saturation logic.
- Gaps in sample_valid stall counting only; the window is always exactly WINDOW accepted samples.
- Output registers update only on entry to REPORT and hold their values until the next REPORT or rst. Between windows they keep the last result.
- start and result_ack in the same cycle while in REPORT: the ack is honoured, the start is ignored, and the next state is IDLE.

Decomposition:
- Shared package interp_pkg holds DATA_W=8, the state enum (IDLE, ACCUM, DRAIN, REPORT), and a function for the absolute difference.
- One sub-module, err_tracker, is instantiated twice (linear and quadratic). It takes the error, x, valid and clear, and produces the sum, max and max_x. The top level holds the FSM, counter and pipeline stages 1-2.

Test Plan:
- rst, then start, then 256 samples with x=0..255, lin=quad=exact=x -> result_valid 3 cycles after the last sample; both sums 0, both maxima 0, both max_x 0, quadratic_better=0.
- Same sweep but lin=exact+2 everywhere and quad=exact except at x=100, where quad=exact-5 -> sum_err_linear=512, max_err_linear=2, max_x_linear=0; sum_err_quadratic=5, max_err_quadratic=5, max_x_quadratic=100; quadratic_better=1.
- Worst case: exact=0, lin=255 for all 256 samples -> sum_err_linear=65280, with no overflow.
- sample_valid toggling every other cycle during ACCUM -> exactly 256 samples counted; results match the contiguous run.
- rst pulsed after 100 samples, then a fresh start and full window -> results reflect only the second window; no residue from the first 100 samples.
- result_ack held low for 10 cycles in REPORT -> outputs and result_valid remain stable. A start during REPORT is ignored. Ack returns to IDLE, and a new start is then accepted.
